// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU codes, opcodes, select values, states.
// The ILLEGAL state exists only when MC_CTRL_ILLEGAL_EN is defined.
package mc_ctrl_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;
    localparam logic [5:0] FUNCT_SLTU = 6'h2b;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MDR = 2'b01;
    localparam logic [1:0] WDSEL_PC  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

`ifdef MC_CTRL_ILLEGAL_EN
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RWB, S_BRANCH, S_JUMP, S_JR, S_ILLEGAL
    } state_e;
`else
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RWB, S_BRANCH, S_JUMP, S_JR
    } state_e;
`endif

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero in, enables/selects/ALUOp out.
// IllegalInstr is present only when MC_CTRL_ILLEGAL_EN is defined.
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       EXTOp;
    logic [1:0] PCSource;
    logic [3:0] ALUOp;
`ifdef MC_CTRL_ILLEGAL_EN
    logic       IllegalInstr;

    modport master (
        input  Op, Funct, Zero,
        output PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, IllegalInstr
    );
    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, IllegalInstr
    );
`else
    modport master (
        input  Op, Funct, Zero,
        output PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp
    );
    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp
    );
`endif
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// State-independent instruction decoder: Op/Funct -> ALU operation, extension mode,
// shift-by-shamt flag and a legality flag for unsupported encodings.
module mc_ctrl_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       is_shamt,
    output logic       legal
);

    always_comb begin
        alu_op   = ALU_NOP;
        ext_op   = 1'b1;
        is_shamt = 1'b0;
        legal    = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  alu_op = ALU_ADD;
                    FUNCT_SUB:  alu_op = ALU_SUB;
                    FUNCT_AND:  alu_op = ALU_AND;
                    FUNCT_OR:   alu_op = ALU_OR;
                    FUNCT_XOR:  alu_op = ALU_XOR;
                    FUNCT_NOR:  alu_op = ALU_NOR;
                    FUNCT_SLT:  alu_op = ALU_SLT;
                    FUNCT_SLTU: alu_op = ALU_SLTU;
                    FUNCT_SLL:  begin alu_op = ALU_SLL; is_shamt = 1'b1; end
                    FUNCT_SRL:  begin alu_op = ALU_SRL; is_shamt = 1'b1; end
                    FUNCT_SRA:  begin alu_op = ALU_SRA; is_shamt = 1'b1; end
                    FUNCT_SLLV: alu_op = ALU_SLL;
                    FUNCT_SRLV: alu_op = ALU_SRL;
                    FUNCT_SRAV: alu_op = ALU_SRA;
                    FUNCT_JR:   alu_op = ALU_NOP;
                    default:    legal  = 1'b0;
                endcase
            end
            OP_ADDI:       alu_op = ALU_ADD;
            OP_SLTI:       alu_op = ALU_SLT;
            OP_ANDI:       begin alu_op = ALU_AND; ext_op = 1'b0; end
            OP_ORI:        begin alu_op = ALU_OR;  ext_op = 1'b0; end
            OP_XORI:       begin alu_op = ALU_XOR; ext_op = 1'b0; end
            OP_LUI:        begin alu_op = ALU_LUI; ext_op = 1'b0; end
            OP_LW, OP_SW:  alu_op = ALU_ADD;
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            OP_J, OP_JAL:  alu_op = ALU_NOP;
            default:       legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller FSM (FETCH/DECODE/EXE/MEM/WB sequencing).
// Define MC_CTRL_ILLEGAL_EN to trap unknown encodings in a sticky ILLEGAL state.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    mc_ctrl_if.master    bus
);

    state_e     state, state_next;
    logic [3:0] dec_alu_op;
    logic       dec_ext_op;
    logic       dec_is_shamt;
    logic       dec_legal;
    logic       is_rtype;
    logic       branch_taken;

    logic       pc_write, ir_write, iord, mem_write, reg_write, ext_op, illegal;
    logic [1:0] reg_dst, wd_sel, src_a, src_b, pc_src;
    logic [3:0] alu_op;

    mc_ctrl_alu_dec u_alu_dec (
        .op       (bus.Op),
        .funct    (bus.Funct),
        .alu_op   (dec_alu_op),
        .ext_op   (dec_ext_op),
        .is_shamt (dec_is_shamt),
        .legal    (dec_legal)
    );

    assign is_rtype     = (bus.Op == OP_RTYPE);
    assign branch_taken = (bus.Op == OP_BNE) ? ~bus.Zero : bus.Zero;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (!dec_legal) begin
`ifdef MC_CTRL_ILLEGAL_EN
                    state_next = S_ILLEGAL;
`else
                    state_next = S_FETCH;
`endif
                end else if (is_mem_op(bus.Op)) begin
                    state_next = S_MEMADR;
                end else if (bus.Op == OP_BEQ || bus.Op == OP_BNE) begin
                    state_next = S_BRANCH;
                end else if (bus.Op == OP_J || bus.Op == OP_JAL) begin
                    state_next = S_JUMP;
                end else if (is_rtype && bus.Funct == FUNCT_JR) begin
                    state_next = S_JR;
                end else begin
                    state_next = S_EXE;
                end
            end
            S_EXE:    state_next = S_RWB;
            S_MEMADR: state_next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
`ifdef MC_CTRL_ILLEGAL_EN
            S_ILLEGAL: state_next = S_ILLEGAL;
`endif
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode the current state; rstn gates them so an aborted instruction
    // cannot complete a register-file or memory write while reset is held.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = REGDST_RT;
        wd_sel    = WDSEL_ALU;
        src_a     = SRCA_PC;
        src_b     = SRCB_RT;
        ext_op    = 1'b0;
        pc_src    = PCSRC_ALU;
        alu_op    = ALU_NOP;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write = 1'b1;
                src_b    = SRCB_FOUR;
                alu_op   = ALU_ADD;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                src_b  = SRCB_IMM_SL2;
                ext_op = 1'b1;
                alu_op = ALU_ADD;
            end
            S_EXE: begin
                alu_op = dec_alu_op;
                if (is_rtype) begin
                    src_a = dec_is_shamt ? SRCA_SHAMT : SRCA_RS;
                    src_b = SRCB_RT;
                end else begin
                    src_a  = SRCA_RS;
                    src_b  = SRCB_IMM;
                    ext_op = dec_ext_op;
                end
            end
            S_RWB: begin
                reg_write = 1'b1;
                wd_sel    = WDSEL_ALU;
                reg_dst   = is_rtype ? REGDST_RD : REGDST_RT;
            end
            S_MEMADR: begin
                src_a  = SRCA_RS;
                src_b  = SRCB_IMM;
                ext_op = 1'b1;
                alu_op = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write = 1'b1;
                wd_sel    = WDSEL_MDR;
                reg_dst   = REGDST_RT;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                src_a    = SRCA_RS;
                src_b    = SRCB_RT;
                alu_op   = ALU_SUB;
                pc_src   = PCSRC_ALUOUT;
                pc_write = branch_taken;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                if (bus.Op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RA;
                    wd_sel    = WDSEL_PC;
                end
            end
            S_JR: begin
                pc_src   = PCSRC_RS;
                pc_write = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_EN
            S_ILLEGAL: illegal = 1'b1;
`endif
            default: ;
        endcase
        if (!rstn) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            iord      = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            reg_dst   = REGDST_RT;
            wd_sel    = WDSEL_ALU;
            src_a     = SRCA_PC;
            src_b     = SRCB_RT;
            ext_op    = 1'b0;
            pc_src    = PCSRC_ALU;
            alu_op    = ALU_NOP;
            illegal   = 1'b0;
        end
    end

    assign bus.PCWrite  = pc_write;
    assign bus.IRWrite  = ir_write;
    assign bus.IorD     = iord;
    assign bus.MemWrite = mem_write;
    assign bus.RegWrite = reg_write;
    assign bus.RegDst   = reg_dst;
    assign bus.WDSel    = wd_sel;
    assign bus.ALUSrcA  = src_a;
    assign bus.ALUSrcB  = src_b;
    assign bus.EXTOp    = ext_op;
    assign bus.PCSource = pc_src;
    assign bus.ALUOp    = alu_op;
`ifdef MC_CTRL_ILLEGAL_EN
    assign bus.IllegalInstr = illegal;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl; every output is packed into one word and compared per cycle.
// Covers the MC_CTRL_ILLEGAL_EN build as well when that macro is defined.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,IRWrite,IorD,MemWrite,RegWrite, RegDst, WDSel, ALUSrcA, ALUSrcB, PCSource, ALUOp, EXTOp}
    logic [19:0] obs;
    assign obs = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemWrite, bus.RegWrite, bus.RegDst,
                  bus.WDSel, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.EXTOp};

    localparam logic [19:0] E_ZERO    = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_FETCH   = {5'b11000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, ALU_ADD, 1'b0};
    localparam logic [19:0] E_DEC     = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, ALU_ADD, 1'b1};
    localparam logic [19:0] E_EXE_ADD = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, ALU_ADD, 1'b0};
    localparam logic [19:0] E_EXE_SLL = {5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, ALU_SLL, 1'b0};
    localparam logic [19:0] E_EXE_ORI = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, ALU_OR, 1'b0};
    localparam logic [19:0] E_RWB_R   = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_RWB_I   = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_MEMADR  = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, ALU_ADD, 1'b1};
    localparam logic [19:0] E_MEMRD   = {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_MEMWB   = {5'b00001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_MEMWR   = {5'b00110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ALU_NOP, 1'b0};
    localparam logic [19:0] E_BR_T    = {5'b10000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, ALU_SUB, 1'b0};
    localparam logic [19:0] E_BR_N    = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, ALU_SUB, 1'b0};
    localparam logic [19:0] E_JAL     = {5'b10001, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, ALU_NOP, 1'b0};
    localparam logic [19:0] E_JR      = {5'b10000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, ALU_NOP, 1'b0};

    task automatic chk(input string tag, input logic [19:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [19:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

`ifdef MC_CTRL_ILLEGAL_EN
    task automatic chk_ill(input string tag, input logic exp);
        vectors++;
        assert (bus.IllegalInstr === exp) else begin
            miscompares++;
            $error("FAIL %s: observed IllegalInstr=%b expected %b", tag, bus.IllegalInstr, exp);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.Op      = OP_RTYPE;
        bus.Funct   = FUNCT_ADD;
        bus.Zero    = 1'b0;
        rstn        = 1'b1;
        #1 rstn     = 1'b0;

        repeat (3) step("reset", E_ZERO);
`ifdef MC_CTRL_ILLEGAL_EN
        chk_ill("reset_ill", 1'b0);
`endif
        rstn = 1'b1;
        #1 chk("rel_fetch", E_FETCH);

        // add: FETCH already checked
        step("add_dec", E_DEC);
        step("add_exe", E_EXE_ADD);
        step("add_rwb", E_RWB_R);

        bus.Op = OP_LW;
        step("lw_fetch", E_FETCH);
        step("lw_dec", E_DEC);
        step("lw_memadr", E_MEMADR);
        step("lw_memrd", E_MEMRD);
        step("lw_memwb", E_MEMWB);

        bus.Op = OP_SW;
        step("sw_fetch", E_FETCH);
        step("sw_dec", E_DEC);
        step("sw_memadr", E_MEMADR);
        step("sw_memwr", E_MEMWR);

        bus.Op   = OP_BEQ;
        bus.Zero = 1'b1;
        step("beq1_fetch", E_FETCH);
        step("beq1_dec", E_DEC);
        step("beq1_branch", E_BR_T);

        bus.Zero = 1'b0;
        step("beq0_fetch", E_FETCH);
        step("beq0_dec", E_DEC);
        step("beq0_branch", E_BR_N);

        bus.Op = OP_BNE;
        step("bne0_fetch", E_FETCH);
        step("bne0_dec", E_DEC);
        step("bne0_branch", E_BR_T);

        bus.Op = OP_JAL;
        step("jal_fetch", E_FETCH);
        step("jal_dec", E_DEC);
        step("jal_jump", E_JAL);

        bus.Op    = OP_RTYPE;
        bus.Funct = FUNCT_SLL;
        step("sll_fetch", E_FETCH);
        step("sll_dec", E_DEC);
        step("sll_exe", E_EXE_SLL);
        step("sll_rwb", E_RWB_R);

        bus.Op = OP_ORI;
        step("ori_fetch", E_FETCH);
        step("ori_dec", E_DEC);
        step("ori_exe", E_EXE_ORI);
        step("ori_rwb", E_RWB_I);

        bus.Op    = OP_RTYPE;
        bus.Funct = FUNCT_JR;
        step("jr_fetch", E_FETCH);
        step("jr_dec", E_DEC);
        step("jr_jr", E_JR);

        bus.Op = 6'h3f;
        step("bad_fetch", E_FETCH);
        step("bad_dec", E_DEC);
`ifdef MC_CTRL_ILLEGAL_EN
        for (int i = 0; i < 3; i++) begin
            step("ill_hold", E_ZERO);
            chk_ill("ill_flag", 1'b1);
        end
        rstn = 1'b0;
        #1 chk("ill_rst", E_ZERO);
        chk_ill("ill_rst_flag", 1'b0);
        rstn = 1'b1;
        #1 chk("ill_rel_fetch", E_FETCH);
        chk_ill("ill_rel_flag", 1'b0);
        bus.Op    = OP_RTYPE;
        bus.Funct = FUNCT_ADD;
`else
        step("bad_op_nop", E_FETCH);
        bus.Op    = OP_RTYPE;
        bus.Funct = 6'h3f;
        step("badf_dec", E_DEC);
        step("badf_nop", E_FETCH);
        bus.Funct = FUNCT_ADD;
`endif

        // reset pulse in EXE of add must abort before RWB
        step("abort_dec", E_DEC);
        step("abort_exe", E_EXE_ADD);
        rstn = 1'b0;
        #1 chk("abort_rst", E_ZERO);
        step("abort_hold", E_ZERO);
        rstn = 1'b1;
        #1 chk("abort_fetch", E_FETCH);
        step("abort_redec", E_DEC);
        step("abort_reexe", E_EXE_ADD);
        step("abort_rwb", E_RWB_R);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
